dsp_signed_div: RTL and testbench

- Iterative signed integer divider; the inverse companion to the pipelined DSP48 multiplier in the vector DoA datapath. Typical use: normalising correlation products by a power/magnitude term.
- Uses a radix-2 restoring algorithm: one quotient bit per clock, fixed latency, valid/ready input handshake.
- Outputs the quotient, the remainder and error flags with a one-cycle output valid strobe.
- Area-lean: no DSP slices, just a subtractor sized DIN2_WIDTH+1 plus shift registers.

---
 rtl/dsp_signed_div.sv | 133 +++++++++++++
 tb/tb_dsp_signed_div.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_signed_div.sv
// Iterative radix-2 restoring signed divider: one quotient bit per clock, fixed latency,
// valid/ready input handshake, quotient/remainder/error flags with a one-cycle valid strobe.
module dsp_signed_div #(
  parameter int DIN1_WIDTH = 32,
  parameter int DIN2_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic [DIN2_WIDTH-1:0] din2,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DIN1_WIDTH-1:0] dout,
  output logic [DIN2_WIDTH-1:0] rem,
  output logic                  dout_valid,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int CW = (DIN1_WIDTH > 1) ? $clog2(DIN1_WIDTH) : 1;
  localparam logic [CW-1:0]         LAST  = CW'(DIN1_WIDTH - 1);
  localparam logic [DIN1_WIDTH-1:0] Q_MAX = {1'b0, {(DIN1_WIDTH-1){1'b1}}};
  localparam logic [DIN1_WIDTH-1:0] Q_MIN = {1'b1, {(DIN1_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                  state, state_next;
  logic                    accept;
  logic                    quo_neg, rem_neg, zero_div, ovf;
  logic [DIN1_WIDTH-1:0]   dvd;       // dividend magnitude, quotient bits shift in at the LSB
  logic [DIN2_WIDTH-1:0]   dvs;
  logic [DIN2_WIDTH-1:0]   prem;
  logic [CW-1:0]           cnt;
  logic [DIN2_WIDTH:0]     shifted, diff;
  logic [DIN1_WIDTH-1:0]   mag1, q_signed;
  logic [DIN2_WIDTH-1:0]   mag2, r_signed;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: defaults are assigned first so no path through the case leaves a latch behind.
  always_comb begin
    state_next = state;
    din_ready  = 1'b0;
    case (state)
      IDLE: begin
        // The strobe cycle still counts as busy, so ready returns the cycle after it.
        din_ready = !dout_valid;
        if (din_valid && !dout_valid) state_next = CALC;
      end
      CALC:    if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign accept = din_valid && din_ready;

  // Magnitudes as unsigned values: the most negative operand maps to 2^(N-1) without overflow.
  assign mag1 = din1[DIN1_WIDTH-1] ? (~din1 + 1'b1) : din1;
  assign mag2 = din2[DIN2_WIDTH-1] ? (~din2 + 1'b1) : din2;

  // prem < |divisor| <= 2^(DIN2_WIDTH-1), so the shifted trial value always fits DIN2_WIDTH+1 bits.
  assign shifted = {prem, dvd[DIN1_WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};

  assign q_signed = quo_neg ? (~dvd + 1'b1) : dvd;
  assign r_signed = rem_neg ? (~prem + 1'b1) : prem;

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_neg     <= 1'b0;
      rem_neg     <= 1'b0;
      zero_div    <= 1'b0;
      ovf         <= 1'b0;
      dvd         <= '0;
      dvs         <= '0;
      prem        <= '0;
      cnt         <= '0;
      dout        <= '0;
      rem         <= '0;
      dout_valid  <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            quo_neg  <= din1[DIN1_WIDTH-1] ^ din2[DIN2_WIDTH-1];
            rem_neg  <= din1[DIN1_WIDTH-1];
            zero_div <= (din2 == '0);
            ovf      <= (din1 == Q_MIN) && (din2 == '1);
            dvd      <= mag1;
            dvs      <= mag2;
            prem     <= '0;
            cnt      <= '0;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (!diff[DIN2_WIDTH]) begin
            prem <= diff[DIN2_WIDTH-1:0];
            dvd  <= {dvd[DIN1_WIDTH-2:0], 1'b1};
          end else begin
            prem <= shifted[DIN2_WIDTH-1:0];
            dvd  <= {dvd[DIN1_WIDTH-2:0], 1'b0};
          end
        end
        DONE: begin
          dout_valid  <= 1'b1;
          div_by_zero <= zero_div;
          overflow    <= ovf;
          if (zero_div) begin
            dout <= rem_neg ? Q_MIN : Q_MAX;
            rem  <= '0;
          end else if (ovf) begin
            dout <= Q_MAX;
            rem  <= '0;
          end else begin
            dout <= q_signed;
            rem  <= r_signed;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_signed_div.sv
// Self-checking bench for dsp_signed_div: directed sign/error cases, handshake timing,
// back-to-back throughput, reset abort and a randomized sweep against an arithmetic model.
module tb_dsp_signed_div;

  localparam int W1 = 32;
  localparam int W2 = 16;
  localparam int LAT = W1 + 2;
  localparam int SPACING = W1 + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [W1-1:0] din1;
  logic [W2-1:0] din2;
  logic          din_valid;
  logic          din_ready;
  logic [W1-1:0] dout;
  logic [W2-1:0] rem;
  logic          dout_valid;
  logic          div_by_zero;
  logic          overflow;

  int n_pass  = 0;
  int n_total = 0;

  dsp_signed_div #(.DIN1_WIDTH(W1), .DIN2_WIDTH(W2)) dut (
    .clk         (clk),
    .rst         (rst),
    .din1        (din1),
    .din2        (din2),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .dout        (dout),
    .rem         (rem),
    .dout_valid  (dout_valid),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: plain signed arithmetic (truncating division, remainder follows the dividend).
  function automatic void ref_div(input longint a, input longint b, output longint q,
                                  output longint r, output logic dz, output logic ov);
    longint q_max, q_min;
    q_max = (longint'(1) <<< (W1 - 1)) - 1;
    q_min = -(longint'(1) <<< (W1 - 1));
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      dz = 1'b1;
      q  = (a >= 0) ? q_max : q_min;
      r  = 0;
    end else if (a == q_min && b == -1) begin
      ov = 1'b1;
      q  = q_max;
      r  = 0;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Entered and left #1 after a rising edge. Latency is in cycles, the accept cycle being 0.
  task automatic run_op(input logic [W1-1:0] a, input logic [W2-1:0] b,
                        output logic [W1-1:0] q, output logic [W2-1:0] r,
                        output logic dz, output logic ov, output int lat);
    int guard = 0;
    q = 'x; r = 'x; dz = 1'bx; ov = 1'bx; lat = -1;
    while (!din_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    din1 = a; din2 = b; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      if (dout_valid) begin
        lat = i; q = dout; r = rem; dz = div_by_zero; ov = overflow;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; din_valid = 1'b0; din1 = '0; din2 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({din_ready, dout_valid, div_by_zero, overflow} !== 4'b1000)
      $display("FAIL reset_ctrl: got %b expected 1000", {din_ready, dout_valid, div_by_zero, overflow});
    else n_pass++;
    n_total++;
    if ({dout, rem} !== '0) $display("FAIL reset_data: dout=%h rem=%h expected 0", dout, rem);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    localparam int N = 12;
    logic [W1-1:0] ta [N] = '{32'd100, -32'sd100, 32'd100, -32'sd100, 32'd5, -32'sd5,
                              32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF,
                              32'd0, 32'd0};
    logic [W2-1:0] tb_ [N] = '{16'd7, 16'd7, -16'sd7, -16'sd7, 16'd0, 16'd0,
                               16'hFFFF, 16'h8000, 16'd1, 16'h8000, 16'd5, 16'd0};
    logic [W1-1:0] tq [N] = '{32'd14, -32'sd14, -32'sd14, 32'd14, 32'h7FFF_FFFF, 32'h8000_0000,
                              32'h7FFF_FFFF, 32'd65536, 32'h8000_0000, -32'sd65535,
                              32'd0, 32'h7FFF_FFFF};
    logic [W2-1:0] tr [N] = '{16'd2, -16'sd2, 16'd2, -16'sd2, 16'd0, 16'd0,
                              16'd0, 16'd0, 16'd0, 16'd32767, 16'd0, 16'd0};
    logic [1:0]    tf [N] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10,
                              2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    logic [W1-1:0] q;
    logic [W2-1:0] r;
    logic          dz, ov;
    int            lat;
    for (int i = 0; i < N; i++) begin
      run_op(ta[i], tb_[i], q, r, dz, ov, lat);
      n_total++;
      if (lat !== LAT) $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, LAT);
      else n_pass++;
      n_total++;
      if ({q, r, dz, ov} !== {tq[i], tr[i], tf[i]})
        $display("FAIL directed_result[%0d] %h/%h: got q=%h r=%h dz=%b ov=%b expected q=%h r=%h flags=%b",
                 i, ta[i], tb_[i], q, r, dz, ov, tq[i], tr[i], tf[i]);
      else n_pass++;
    end
  endtask

  // Busy-period behaviour: ready low from accept through the strobe, din_valid ignored, output hold.
  task automatic test_handshake();
    int ready_bad = 0;
    int valid_cycle = -1;
    int guard = 0;
    while (!din_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    din1 = 32'd100; din2 = 16'd7; din_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= LAT; i++) begin
      din1 = $urandom; din2 = 16'(($urandom % 100) + 1);
      if (i == LAT) din_valid = 1'b0;
      if (din_ready) ready_bad++;
      if (dout_valid && valid_cycle < 0) valid_cycle = i;
      if (i < LAT) begin
        @(posedge clk); #1;
      end
    end
    n_total++;
    if (ready_bad != 0) $display("FAIL busy_ready: ready high in %0d busy cycles, expected 0", ready_bad);
    else n_pass++;
    n_total++;
    if (valid_cycle != LAT) $display("FAIL busy_latency: got %0d expected %0d", valid_cycle, LAT);
    else n_pass++;
    n_total++;
    if ({dout, rem} !== {32'd14, 16'd2}) $display("FAIL busy_result: got q=%0d r=%0d expected 14 2",
                                                  $signed(dout), $signed(rem));
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({din_ready, dout_valid} !== 2'b10)
      $display("FAIL after_strobe: ready/valid got %b expected 10", {din_ready, dout_valid});
    else n_pass++;
    n_total++;
    if ({dout, rem} !== {32'd14, 16'd2}) $display("FAIL output_hold: got q=%h r=%h expected 14 2", dout, rem);
    else n_pass++;
  endtask

  // din_valid held high with new data every cycle; only accept-edge data may be used.
  task automatic test_back_to_back();
    longint exp_q [$];
    longint exp_r [$];
    longint q, r;
    logic   dz, ov;
    int     results = 0;
    int     last_valid = -1;
    int     cyc = 0;
    while (results < 4 && cyc < 400) begin
      if (dout_valid) begin
        n_total++;
        if (exp_q.size() == 0) $display("FAIL b2b_unexpected: strobe with no accepted operation");
        else begin
          q = exp_q.pop_front();
          r = exp_r.pop_front();
          if (longint'($signed(dout)) != q || longint'($signed(rem)) != r)
            $display("FAIL b2b_result: got q=%0d r=%0d expected q=%0d r=%0d",
                     $signed(dout), $signed(rem), q, r);
          else n_pass++;
        end
        if (last_valid >= 0) begin
          n_total++;
          if (cyc - last_valid != SPACING)
            $display("FAIL b2b_spacing: got %0d expected %0d", cyc - last_valid, SPACING);
          else n_pass++;
        end
        last_valid = cyc;
        results++;
      end
      din1 = $urandom;
      din2 = 16'($urandom);
      din_valid = 1'b1;
      if (din_ready) begin
        ref_div(longint'($signed(din1)), longint'($signed(din2)), q, r, dz, ov);
        exp_q.push_back(q);
        exp_r.push_back(r);
      end
      @(posedge clk); #1;
      cyc++;
    end
    din_valid = 1'b0;
    n_total++;
    if (results != 4) $display("FAIL b2b_count: got %0d results expected 4", results);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [W1-1:0] q;
    logic [W2-1:0] r;
    logic          dz, ov;
    int            lat;
    int            stray = 0;
    int            guard = 0;
    while (!din_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    din1 = 32'd1000; din2 = 16'd3; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_total++;
    if ({din_ready, dout_valid, div_by_zero, overflow, dout, rem} !== {4'b1000, 48'd0})
      $display("FAIL reset_mid_state: ready=%b valid=%b dz=%b ov=%b dout=%h rem=%h expected 1,0,0,0,0,0",
               din_ready, dout_valid, div_by_zero, overflow, dout, rem);
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      if (dout_valid) stray++;
      @(posedge clk); #1;
    end
    n_total++;
    if (stray != 0) $display("FAIL reset_mid_abort: got %0d strobes expected 0", stray);
    else n_pass++;
    run_op(32'd9, 16'd3, q, r, dz, ov, lat);
    n_total++;
    if ({q, r, dz, ov} !== {32'd3, 16'd0, 2'b00} || lat != LAT)
      $display("FAIL after_reset_op: got q=%0d r=%0d dz=%b ov=%b lat=%0d expected 3 0 0 0 %0d",
               q, r, dz, ov, lat, LAT);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [W1-1:0] a, q;
    logic [W2-1:0] b, r;
    logic          dz, ov, edz, eov;
    longint        eq, er, sa, sb, sq, sr;
    int            lat;
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = 32'($signed($urandom_range(0, 2000)) - 1000);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0:       b = 16'd0;
        1:       b = 16'hFFFF;
        2:       b = 16'h8000;
        3:       b = 16'($signed($urandom_range(0, 20)) - 10);
        default: b = 16'($urandom);
      endcase
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ref_div(sa, sb, eq, er, edz, eov);
      run_op(a, b, q, r, dz, ov, lat);
      sq = longint'($signed(q));
      sr = longint'($signed(r));
      n_total++;
      if (sq != eq || sr != er || dz !== edz || ov !== eov || lat != LAT)
        $display("FAIL random[%0d] %0d/%0d: got q=%0d r=%0d dz=%b ov=%b lat=%0d expected q=%0d r=%0d dz=%b ov=%b lat=%0d",
                 n, sa, sb, sq, sr, dz, ov, lat, eq, er, edz, eov, LAT);
      else n_pass++;
      if (!edz && !eov) begin
        n_total++;
        if (sa != sq * sb + sr || (sr < 0 ? -sr : sr) >= (sb < 0 ? -sb : sb))
          $display("FAIL invariant[%0d] %0d/%0d: q=%0d r=%0d", n, sa, sb, sq, sr);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
